// File: rtl/data_memory_block_pkg.sv
// Shared definitions for the block data memory and its requester (data cache).
//   - FSM state encoding for the memory responder
//   - Default block/address widths shared with the requesting cache
//   - Default storage depth and access latency
package dmem_pkg;

  localparam int unsigned ADDR_W  = 28;   // block address width (word address >> 2)
  localparam int unsigned BLOCK_W = 128;  // 4 x 32-bit words
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned DEPTH_W = 6;    // 64 blocks stored
  localparam int unsigned LATENCY = 4;    // BUSY cycles per access, 1..15

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    ACK  = 2'b10
  } dmem_state_t;

  // Counter preload for a given latency; the counter counts down to zero.
  function automatic logic [3:0] lat_preload(input int unsigned lat);
    return 4'(lat - 1);
  endfunction

endpackage

// File: rtl/data_memory_block_if.sv
// Refill/write-back bus between the data cache (master) and the block data
// memory (slave).
//   READ, WRITE  : level requests, held by the master until BUSYWAIT drops
//   BLOCK_ADDR   : block address, sampled at accept
//   WRITE_DATA   : block to store, sampled at accept
//   BUSYWAIT     : stall back to the master
//   READ_DATA    : block returned by the last completed read
interface data_memory_block_if #(
  parameter int unsigned ADDR_W  = dmem_pkg::ADDR_W,
  parameter int unsigned BLOCK_W = dmem_pkg::BLOCK_W
);
  logic               READ;
  logic               WRITE;
  logic [ADDR_W-1:0]  BLOCK_ADDR;
  logic [BLOCK_W-1:0] WRITE_DATA;
  logic               BUSYWAIT;
  logic [BLOCK_W-1:0] READ_DATA;

  modport master (
    output READ, WRITE, BLOCK_ADDR, WRITE_DATA,
    input  BUSYWAIT, READ_DATA
  );

  modport slave (
    input  READ, WRITE, BLOCK_ADDR, WRITE_DATA,
    output BUSYWAIT, READ_DATA
  );
endinterface

// File: rtl/data_memory_block_array.sv
// Single-port block storage, 2^DEPTH_W x BLOCK_W.
//   clk      : clock
//   i_en     : access enable
//   i_we     : write (1) / read (0) when enabled
//   i_addr   : block index
//   i_wdata  : block to store
//   o_rdata  : registered read result, updated only by enabled reads
// No reset: contents and read register survive RESET of the controller.
module dmem_array #(
  parameter int unsigned DEPTH_W = 6,
  parameter int unsigned BLOCK_W = 128
) (
  input  logic               clk,
  input  logic               i_en,
  input  logic               i_we,
  input  logic [DEPTH_W-1:0] i_addr,
  input  logic [BLOCK_W-1:0] i_wdata,
  output logic [BLOCK_W-1:0] o_rdata
);

  logic [BLOCK_W-1:0] r_mem [2**DEPTH_W];
  logic [BLOCK_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_memory_block.sv
// Block-granular data memory: responder end of the data cache refill /
// write-back bus. One 128-bit block read or write per request, stalled for a
// fixed LATENCY via BUSYWAIT, then one ACK cycle with BUSYWAIT low.
//   CLK    : clock, all state changes on posedge
//   RESET  : asynchronous, active-high
//   bus    : slave side of data_memory_block_if
//            (READ/WRITE/BLOCK_ADDR/WRITE_DATA in, BUSYWAIT/READ_DATA out)
module data_memory_block #(
  parameter int unsigned ADDR_W  = dmem_pkg::ADDR_W,
  parameter int unsigned BLOCK_W = dmem_pkg::BLOCK_W,
  parameter int unsigned DEPTH_W = dmem_pkg::DEPTH_W,
  parameter int unsigned LATENCY = dmem_pkg::LATENCY
) (
  input  logic                CLK,
  input  logic                RESET,
  data_memory_block_if.slave  bus
);

  import dmem_pkg::*;

  localparam logic [3:0] LP_PRELOAD = lat_preload(LATENCY);

  dmem_state_t        r_state;
  dmem_state_t        w_next;
  logic [3:0]         r_cnt;
  logic               r_is_write;
  logic [DEPTH_W-1:0] r_idx;
  logic [BLOCK_W-1:0] r_wdata;
  logic [BLOCK_W-1:0] r_read_data;

  logic               w_req;
  logic               w_accept;
  logic               w_done;
  logic               w_arr_en;
  logic               w_arr_we;
  logic [DEPTH_W-1:0] w_arr_addr;
  logic [BLOCK_W-1:0] w_arr_q;
  logic               w_unused_addr_hi;

  assign w_req    = bus.READ | bus.WRITE;
  assign w_accept = (r_state == IDLE) && w_req && !RESET;
  assign w_done   = (r_state == BUSY) && (r_cnt == '0);

  // Address bits above the index alias onto the same block.
  assign w_unused_addr_hi = ^bus.BLOCK_ADDR[ADDR_W-1:DEPTH_W];

  // FSM state register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next state
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_req)        w_next = BUSY;
      BUSY:    if (r_cnt == '0)  w_next = ACK;
      ACK:                       w_next = IDLE;
      default:                   w_next = IDLE;
    endcase
  end

  // Request latches, latency counter and read-data register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_cnt       <= '0;
      r_is_write  <= 1'b0;
      r_idx       <= '0;
      r_wdata     <= '0;
      r_read_data <= '0;
    end else begin
      if (w_accept) begin
        r_cnt      <= LP_PRELOAD;
        r_is_write <= bus.WRITE;  // WRITE wins when both are high
        r_idx      <= bus.BLOCK_ADDR[DEPTH_W-1:0];
        r_wdata    <= bus.WRITE_DATA;
      end else if ((r_state == BUSY) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_done && !r_is_write) begin
        r_read_data <= w_arr_q;
      end
    end
  end

  // The array read is issued at accept so its registered output is settled
  // for the whole BUSY window (nothing else touches the array meanwhile);
  // it is copied into READ_DATA only at completion, which keeps READ_DATA
  // resettable and unchanged by reads that are dropped by RESET.
  assign w_arr_en   = (w_accept && !bus.WRITE) || (w_done && r_is_write);
  assign w_arr_we   = w_done && r_is_write;
  assign w_arr_addr = (r_state == IDLE) ? bus.BLOCK_ADDR[DEPTH_W-1:0] : r_idx;

  dmem_array #(
    .DEPTH_W (DEPTH_W),
    .BLOCK_W (BLOCK_W)
  ) u_array (
    .clk     (CLK),
    .i_en    (w_arr_en),
    .i_we    (w_arr_we),
    .i_addr  (w_arr_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_arr_q)
  );

  assign bus.BUSYWAIT  = !RESET && (w_accept || (r_state == BUSY));
  assign bus.READ_DATA = r_read_data;

endmodule

// File: tb/tb_data_memory_block.sv
module tb_data_memory_block;

  localparam int unsigned LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model: plain array of blocks plus last completed read value.
  logic [127:0] mdl_mem [64];
  logic [127:0] mdl_rd;

  data_memory_block_if #(.ADDR_W(28), .BLOCK_W(128)) bus ();

  data_memory_block #(
    .ADDR_W  (28),
    .BLOCK_W (128),
    .DEPTH_W (6),
    .LATENCY (LAT)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Waits out the BUSY window of an accepted request, then checks length,
  // ACK and READ_DATA against the model. Leaves the bench in the ACK cycle
  // with requests dropped.
  task automatic finish(input bit rd, input bit wr, input logic [27:0] a,
                        input logic [127:0] d, input bit churn);
    int n = 0;
    bit done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(posedge clk); #1;
      if (!bus.BUSYWAIT) begin
        done = 1;
      end else begin
        n++;
        if (churn && n == 2) begin
          bus.BLOCK_ADDR = 28'($urandom);
          bus.WRITE_DATA = rnd128();
          bus.WRITE      = 1'b0;
        end
      end
    end
    check("ack_seen", 128'(done), 128'(1));
    check("busy_len", 128'(n), 128'(LAT));
    if (wr) mdl_mem[a[5:0]] = d;
    else if (rd) mdl_rd = mdl_mem[a[5:0]];
    check("ack_rdata", bus.READ_DATA, mdl_rd);
    bus.READ  = 1'b0;
    bus.WRITE = 1'b0;
  endtask

  // b2b=0: step into the following IDLE cycle first and check it is idle.
  // b2b=1: raise the request inside the ACK cycle.
  task automatic access(input bit rd, input bit wr, input logic [27:0] a,
                        input logic [127:0] d, input bit b2b, input bit churn);
    if (!b2b) begin
      @(posedge clk); #1;
      check("idle_low", 128'(bus.BUSYWAIT), 128'(0));
    end
    bus.READ       = rd;
    bus.WRITE      = wr;
    bus.BLOCK_ADDR = a;
    bus.WRITE_DATA = d;
    #1;
    if (b2b) begin
      check("ack_low_b2b", 128'(bus.BUSYWAIT), 128'(0));
      @(posedge clk); #1;
    end
    check("busy_start", 128'(bus.BUSYWAIT), 128'(1));
    finish(rd, wr, a, d, churn);
  endtask

  logic [127:0] v;
  logic [27:0]  ra;
  bit           rrd, rwr;

  initial begin
    bus.READ = 1'b0; bus.WRITE = 1'b0;
    bus.BLOCK_ADDR = '0; bus.WRITE_DATA = '0;
    mdl_rd = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 128'(bus.BUSYWAIT), 128'(0));
    check("rst_rdata", bus.READ_DATA, 128'(0));
    rst = 1'b0;

    // Give every block a known value
    for (int i = 0; i < 64; i++) access(1'b0, 1'b1, 28'(i), rnd128(), 1'b0, 1'b0);

    // 1: write then read
    access(1'b0, 1'b1, 28'h0000005, 128'hDEADBEEF_0BADF00D_CAFEBABE_12345678, 1'b0, 1'b0);
    access(1'b1, 1'b0, 28'h0000005, '0, 1'b0, 1'b0);
    check("t1_value", bus.READ_DATA, 128'hDEADBEEF_0BADF00D_CAFEBABE_12345678);

    // 2: write-back then refill raised in the ACK cycle
    access(1'b0, 1'b1, 28'h0000003, rnd128(), 1'b0, 1'b0);
    access(1'b1, 1'b0, 28'h0000013, '0, 1'b1, 1'b0);

    // 3: input churn during BUSY
    v = rnd128();
    access(1'b0, 1'b1, 28'h000002A, v, 1'b0, 1'b1);
    access(1'b1, 1'b0, 28'h000002A, '0, 1'b0, 1'b0);
    check("t3_value", bus.READ_DATA, v);

    // 4: READ and WRITE together act as a write
    access(1'b1, 1'b1, 28'h0000007, 128'h1, 1'b0, 1'b0);
    access(1'b1, 1'b0, 28'h0000007, '0, 1'b0, 1'b0);
    check("t4_value", bus.READ_DATA, 128'h1);

    // 5: aliasing of upper address bits
    access(1'b0, 1'b1, 28'h0000041, 128'hA5, 1'b0, 1'b0);
    access(1'b1, 1'b0, 28'h0000001, '0, 1'b0, 1'b0);
    check("t5_value", bus.READ_DATA, 128'hA5);

    // 6: reset during BUSY cycle 2 of a write to 9; held READ restarts
    @(posedge clk); #1;
    bus.WRITE = 1'b1; bus.BLOCK_ADDR = 28'h9; bus.WRITE_DATA = ~mdl_mem[9];
    #1;
    check("t6_start", 128'(bus.BUSYWAIT), 128'(1));
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    mdl_rd = '0;
    check("t6_rst_busy", 128'(bus.BUSYWAIT), 128'(0));
    check("t6_rst_rdata", bus.READ_DATA, 128'(0));
    bus.WRITE = 1'b0; bus.READ = 1'b1;
    #1;
    check("t6_rst_busy_rd", 128'(bus.BUSYWAIT), 128'(0));
    @(posedge clk); #1;
    check("t6_rst_hold", 128'(bus.BUSYWAIT), 128'(0));
    rst = 1'b0;
    #1;
    check("t6_restart", 128'(bus.BUSYWAIT), 128'(1));
    finish(1'b1, 1'b0, 28'h9, '0, 1'b0);

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      rrd = 1'($urandom);
      rwr = 1'($urandom);
      if (!rrd && !rwr) rrd = 1'b1;
      ra  = 28'($urandom);
      access(rrd, rwr, ra, rnd128(), 1'($urandom_range(0, 3) == 0), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
